user_wr_ctrl: RTL and testbench

Burst write controller for the DDR3 memory-controller user write port (p0). It is the write-side counterpart of the frame read controller. On each wr_start it does two things:
- Pulls BURST_LEN 128-bit words from an upstream first-word-fall-through (FWFT) FIFO into the controller write-data FIFO.
- Then issues one write command at the current frame address, which advances and wraps per frame (1024x768, 16 bit/pixel).

---
 rtl/user_wr_ctrl.sv | 105 ++++++++++
 tb/tb_user_wr_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/user_wr_ctrl.sv
// Burst write controller for the DDR3 user write port p0: moves BURST_LEN words
// from an upstream FWFT FIFO into the write-data FIFO, then issues one write command.
module user_wr_ctrl #(
    parameter int unsigned BURST_LEN  = 64,
    parameter int unsigned START_ADDR = 0,
    parameter int unsigned STOP_ADDR  = 785920,
    parameter int unsigned ADDR_ADD   = 512
) (
    input  logic         sclk,
    input  logic         rst,
    input  logic         wr_start,
    output logic         src_rd_en,
    input  logic [127:0] src_data,
    output logic         p0_cmd_en,
    output logic [2:0]   p0_cmd_instr,
    output logic [6:0]   p0_cmd_bl,
    output logic [27:0]  p0_cmd_addr,
    input  logic         p0_cmd_full,
    output logic         p0_wr_en,
    output logic [127:0] p0_wr_data,
    output logic [15:0]  p0_wr_mask,
    input  logic         p0_wr_full,
    output logic         busy,
    output logic         user_wr_end,
    output logic         frame_end,
    output logic [1:0]   state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        CMD  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [6:0]  LAST_CNT = 7'(BURST_LEN - 1);
    localparam logic [27:0] START_A  = 28'(START_ADDR);
    localparam logic [27:0] STOP_A   = 28'(STOP_ADDR);
    localparam logic [27:0] ADD_A    = 28'(ADDR_ADD);

    state_t      state;
    logic [6:0]  data_cnt;
    logic [27:0] addr;
    logic        word_acc;
    logic        cmd_acc;

    // Handshake: a word moves when p0_wr_en is high (valid from DATA state) and
    // p0_wr_full is low (ready); the same strobe pops the FWFT source, so a
    // stalled word stays at the source head and is offered again next cycle.
    // The command moves on the same rule with p0_cmd_en / p0_cmd_full.
    assign word_acc = (state == DATA) && !p0_wr_full;
    assign cmd_acc  = (state == CMD) && !p0_cmd_full;

    always_ff @(posedge sclk) begin
        if (rst) begin
            state    <= IDLE;
            data_cnt <= 7'd0;
            addr     <= START_A;
        end else begin
            case (state)
                IDLE: begin
                    if (wr_start)
                        state <= DATA;
                end
                DATA: begin
                    if (word_acc) begin
                        if (data_cnt == LAST_CNT) begin
                            data_cnt <= 7'd0;
                            state    <= CMD;
                        end else begin
                            data_cnt <= data_cnt + 7'd1;
                        end
                    end
                end
                CMD: begin
                    if (cmd_acc)
                        state <= DONE;
                end
                DONE: begin
                    // Address wraps to the frame start after the last burst
                    if (addr == STOP_A)
                        addr <= START_A;
                    else
                        addr <= addr + ADD_A;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign src_rd_en    = word_acc;
    assign p0_wr_en     = word_acc;
    assign p0_wr_data   = src_data;
    assign p0_wr_mask   = 16'd0;
    assign p0_cmd_en    = cmd_acc;
    assign p0_cmd_instr = 3'd0;
    assign p0_cmd_bl    = 7'(BURST_LEN);
    assign p0_cmd_addr  = addr;
    assign busy         = (state != IDLE);
    assign user_wr_end  = (state == DONE);
    assign frame_end    = (state == DONE) && (addr == STOP_A);
    assign state_dbg    = state;

endmodule

// File: tb/tb_user_wr_ctrl.sv
// Bench for user_wr_ctrl: randomized bursts and backpressure checked cycle by
// cycle against a count-based reference model and an expected-data queue.
module tb_user_wr_ctrl;
    localparam int BL           = 64;
    localparam int START        = 0;
    localparam int ADD          = 512;
    localparam int STOP         = 2560;
    localparam int FRAME_BURSTS = (STOP - START) / ADD + 1;

    logic         sclk;
    logic         rst;
    logic         wr_start;
    logic         src_rd_en;
    logic [127:0] src_data;
    logic         p0_cmd_en;
    logic [2:0]   p0_cmd_instr;
    logic [6:0]   p0_cmd_bl;
    logic [27:0]  p0_cmd_addr;
    logic         p0_cmd_full;
    logic         p0_wr_en;
    logic [127:0] p0_wr_data;
    logic [15:0]  p0_wr_mask;
    logic         p0_wr_full;
    logic         busy;
    logic         user_wr_end;
    logic         frame_end;
    logic [1:0]   state_dbg;

    user_wr_ctrl #(
        .BURST_LEN (BL),
        .START_ADDR(START),
        .STOP_ADDR (STOP),
        .ADDR_ADD  (ADD)
    ) dut (
        .sclk        (sclk),
        .rst         (rst),
        .wr_start    (wr_start),
        .src_rd_en   (src_rd_en),
        .src_data    (src_data),
        .p0_cmd_en   (p0_cmd_en),
        .p0_cmd_instr(p0_cmd_instr),
        .p0_cmd_bl   (p0_cmd_bl),
        .p0_cmd_addr (p0_cmd_addr),
        .p0_cmd_full (p0_cmd_full),
        .p0_wr_en    (p0_wr_en),
        .p0_wr_data  (p0_wr_data),
        .p0_wr_mask  (p0_wr_mask),
        .p0_wr_full  (p0_wr_full),
        .busy        (busy),
        .user_wr_end (user_wr_end),
        .frame_end   (frame_end),
        .state_dbg   (state_dbg)
    );

    // clock / reset block
    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    // scoreboard state
    logic [127:0] src_q[$];
    logic [127:0] exp_q[$];
    bit           pop_pending = 0;
    int           n_checks = 0;
    int           n_pass = 0;
    int           n_end_obs = 0;
    int           n_bursts_exp = 0;

    // reference model: progress of the current burst in words and milestones
    bit m_active = 0;
    int m_words = 0;
    bit m_cmd_done = 0;
    int m_burst = 0;

    function automatic logic [27:0] model_addr();
        return 28'(START + (m_burst % FRAME_BURSTS) * ADD);
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    // One clock: drive after the edge, sample at the falling edge, then step the model.
    task automatic cycle(input logic s, input logic wf, input logic cf, input logic r);
        logic exp_wr, exp_cmd, exp_end;
        logic [27:0] a;
        @(posedge sclk);
        #1;
        if (pop_pending) begin
            if (src_q.size() > 0) void'(src_q.pop_front());
            pop_pending = 0;
        end
        wr_start    = s;
        p0_wr_full  = wf;
        p0_cmd_full = cf;
        rst         = r;
        src_data    = (src_q.size() > 0) ? src_q[0] : 128'd0;
        @(negedge sclk);
        a       = model_addr();
        exp_wr  = m_active && (m_words < BL) && !wf;
        exp_cmd = m_active && (m_words == BL) && !m_cmd_done && !cf;
        exp_end = m_active && m_cmd_done;
        check("p0_wr_en", p0_wr_en, exp_wr);
        check("src_rd_en", src_rd_en, exp_wr);
        check("p0_cmd_en", p0_cmd_en, exp_cmd);
        check("user_wr_end", user_wr_end, exp_end);
        check("frame_end", frame_end, exp_end && (a == 28'(STOP)));
        check("busy", busy, m_active);
        check("p0_cmd_addr", p0_cmd_addr, a);
        if (p0_wr_en) begin
            pop_pending = 1;
            if (exp_q.size() == 0)
                check("wr_data_unexpected", p0_wr_data, 128'hx);
            else
                check("p0_wr_data", p0_wr_data, exp_q.pop_front());
        end
        if (user_wr_end) n_end_obs++;
        if (exp_wr) m_words++;
        if (exp_cmd) m_cmd_done = 1;
        if (exp_end) begin
            m_active = 0;
            m_burst++;
        end else if (!m_active && s) begin
            m_active   = 1;
            m_words    = 0;
            m_cmd_done = 0;
        end
        if (r) begin
            m_active    = 0;
            m_words     = 0;
            m_cmd_done  = 0;
            m_burst     = 0;
            pop_pending = 0;
            src_q.delete();
            exp_q.delete();
        end
    endtask

    task automatic load_words(input bit incr);
        logic [127:0] w;
        for (int i = 0; i < BL; i++) begin
            w = incr ? 128'(i) : {$urandom, $urandom, $urandom, $urandom};
            src_q.push_back(w);
            exp_q.push_back(w);
        end
    endtask

    // mode 0: no backpressure; 1: wr_full 5 cycles at word 10 and on last word;
    // 2: random wr_full / cmd_full and stray wr_start pulses
    task automatic run_burst(input int mode, input int cfull_hold, input bit incr);
        int guard, h10, hl, hc;
        logic wf, cf, s;
        load_words(incr);
        n_bursts_exp++;
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        guard = 0; h10 = 0; hl = 0; hc = 0;
        while (m_active && guard < 500) begin
            wf = 0; cf = 0; s = 0;
            if (mode == 1) begin
                if (m_words == 10 && h10 < 5) begin
                    wf = 1; h10++;
                end else if (m_words == BL - 1 && hl < 5) begin
                    wf = 1; hl++;
                end
            end else if (mode == 2) begin
                wf = ($urandom_range(0, 3) == 0);
                cf = ($urandom_range(0, 3) == 0);
                s  = ($urandom_range(0, 7) == 0);
            end
            if (m_words == BL && !m_cmd_done && hc < cfull_hold) begin
                cf = 1; hc++;
            end
            cycle(s, wf, cf, 1'b0);
            guard++;
        end
        check("bursts_completed", 128'(n_end_obs), 128'(n_bursts_exp));
    endtask

    initial begin
        rst = 1; wr_start = 0; p0_wr_full = 0; p0_cmd_full = 0; src_data = '0;
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (10) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check("p0_cmd_instr", p0_cmd_instr, 0);
        check("p0_cmd_bl", p0_cmd_bl, BL);
        check("p0_wr_mask", p0_wr_mask, 0);
        check("state_dbg_idle", state_dbg, 0);

        run_burst(0, 0, 1'b1);
        run_burst(0, 0, 1'b0);
        run_burst(1, 0, 1'b0);
        run_burst(0, 8, 1'b0);
        repeat (7) run_burst(0, 0, 1'b0);
        repeat (6) begin
            repeat ($urandom_range(0, 3)) cycle(1'b0, 1'b0, 1'b0, 1'b0);
            run_burst(2, $urandom_range(0, 3), 1'b0);
        end

        // abort a burst mid-way, with a stray start while in DATA
        load_words(1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cycle(i == 5, 1'b0, 1'b0, 1'b0);
        repeat (2) cycle(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (5) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check("state_dbg_after_rst", state_dbg, 0);
        check("addr_after_rst", p0_cmd_addr, START);

        run_burst(0, 0, 1'b1);
        run_burst(2, 2, 1'b0);
        check("p0_cmd_bl_end", p0_cmd_bl, BL);
        check("p0_wr_mask_end", p0_wr_mask, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
